// File: rtl/i2s_rx_core.sv
// I2S / left-justified receive master: SCK/WS generation, stereo capture, valid/ready out.
// Optional sticky overrun flag (ovf/ovf_clr) when I2S_RX_OVF_EN is defined.
module i2s_rx_core #(
  parameter int CLK_DIV   = 28,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 en,
  input  logic                 lj_mode,
  input  logic                 SD_input,
  output logic                 SCK_output,
  output logic                 WS_output,
  output logic [DATA_BITS-1:0] L_Data,
  output logic [DATA_BITS-1:0] R_Data,
  output logic                 valid,
  input  logic                 ready
`ifdef I2S_RX_OVF_EN
  ,
  output logic                 ovf,
  input  logic                 ovf_clr
`endif
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_STB  = PW'(CLK_DIV / 2 - 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] WS_START = BW'(SLOT_BITS);

  // Capture window bounds (inclusive) for both data delays.
  localparam logic [BW-1:0] L_LO_LJ  = BW'(0);
  localparam logic [BW-1:0] L_LO_I2S = BW'(1);
  localparam logic [BW-1:0] L_HI_LJ  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] L_HI_I2S = BW'(DATA_BITS);
  localparam logic [BW-1:0] R_LO_LJ  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] R_LO_I2S = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0] R_HI_LJ  = BW'(SLOT_BITS + DATA_BITS - 1);
  localparam logic [BW-1:0] R_HI_I2S = BW'(SLOT_BITS + DATA_BITS);

  logic [PW-1:0]        phase;
  logic [BW-1:0]        bit_idx;
  logic                 lj_q;
  logic [DATA_BITS-1:0] l_sr;
  logic [DATA_BITS-1:0] r_sr;
  logic                 done_q;

  logic          strobe;
  logic [BW-1:0] l_lo, l_hi, r_lo, r_hi;
  logic          l_win, r_win, done;
  logic          overrun;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase   <= '0;
      bit_idx <= '0;
    end else if (!en) begin
      phase   <= '0;
      bit_idx <= '0;
    end else if (phase == PH_LAST) begin
      phase   <= '0;
      if (bit_idx == BIT_LAST) bit_idx <= '0;
      else                     bit_idx <= bit_idx + 1'b1;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Mode is latched once per frame so mid-frame changes wait for the next frame.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lj_q <= 1'b0;
    end else if (bit_idx == '0 && phase == '0) begin
      lj_q <= lj_mode;
    end
  end

  assign SCK_output = (phase > PH_STB);
  assign WS_output  = (bit_idx >= WS_START);

  always_comb begin
    strobe = en && (phase == PH_STB);
    l_lo   = lj_q ? L_LO_LJ : L_LO_I2S;
    l_hi   = lj_q ? L_HI_LJ : L_HI_I2S;
    r_lo   = lj_q ? R_LO_LJ : R_LO_I2S;
    r_hi   = lj_q ? R_HI_LJ : R_HI_I2S;
    l_win  = (bit_idx >= l_lo) && (bit_idx <= l_hi);
    r_win  = (bit_idx >= r_lo) && (bit_idx <= r_hi);
    done   = strobe && (bit_idx == r_hi);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      l_sr   <= '0;
      r_sr   <= '0;
      done_q <= 1'b0;
    end else if (!en) begin
      l_sr   <= '0;
      r_sr   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (strobe && l_win) l_sr <= {l_sr[DATA_BITS-2:0], SD_input};
      if (strobe && r_win) r_sr <= {r_sr[DATA_BITS-2:0], SD_input};
    end
  end

  assign overrun = done_q && valid && !ready;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      L_Data <= '0;
      R_Data <= '0;
      valid  <= 1'b0;
    end else if (done_q) begin
      L_Data <= l_sr;
      R_Data <= r_sr;
      valid  <= 1'b1;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

`ifdef I2S_RX_OVF_EN
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)     ovf <= 1'b0;
    else if (overrun) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_overrun;
  assign unused_overrun = overrun;
`endif

endmodule

// File: tb/tb_i2s_rx_core.sv
// Directed bench for i2s_rx_core with a frame scoreboard (CLK_DIV=4, 256-clk frames).
// ovf checks are compiled in only when I2S_RX_OVF_EN is defined.
module tb_i2s_rx_core;

  localparam int CD = 4;
  localparam int SB = 32;
  localparam int DB = 24;

  logic clk = 1'b0;
  logic Reset_n;
  logic en;
  logic lj_mode;
  logic SD_input;
  logic ready;
  logic SCK_output;
  logic WS_output;
  logic [DB-1:0] L_Data;
  logic [DB-1:0] R_Data;
  logic valid;
`ifdef I2S_RX_OVF_EN
  logic ovf;
  logic ovf_clr;
`endif

  always #5 clk = ~clk;

  i2s_rx_core #(
    .CLK_DIV  (CD),
    .SLOT_BITS(SB),
    .DATA_BITS(DB)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .en        (en),
    .lj_mode   (lj_mode),
    .SD_input  (SD_input),
    .SCK_output(SCK_output),
    .WS_output (WS_output),
    .L_Data    (L_Data),
    .R_Data    (R_Data),
    .valid     (valid),
    .ready     (ready)
`ifdef I2S_RX_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`endif
  );

  typedef struct packed {
    logic [DB-1:0] l;
    logic [DB-1:0] r;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt = 0;
  int t0 = 0;
  logic [DB-1:0] fl[8];
  logic [DB-1:0] fr[8];
  int fdly[8];

  // Serial source: tracks its own frame position and pushes the expected
  // frame once its last captured bit has been driven.
  initial begin
    SD_input = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!Reset_n || !en) cnt = 0;
      else cnt++;
      @(negedge clk);
      begin
        int f, b, ph, d;
        f  = (cnt / 256) % 8;
        b  = (cnt / 4) % 64;
        ph = cnt % 4;
        d  = fdly[f];
        if (b >= d && b < d + DB)
          SD_input = fl[f][DB-1-(b-d)];
        else if (b >= SB + d && b < SB + d + DB)
          SD_input = fr[f][DB-1-(b-SB-d)];
        else
          SD_input = 1'($urandom_range(1, 0));
        if (en && Reset_n && ph == 1 && b == SB + d + DB - 1)
          q.push_back({fl[f], fr[f]});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start();
    en = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (valid) break;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_lat"}, 32'(cyc - t0), 32'(lat));
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_qsize"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_L"}, 32'(L_Data), 32'(e.l));
      chk({tag, "_R"}, 32'(R_Data), 32'(e.r));
    end
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk({tag, "_acc"}, 32'(valid), 32'd0);
  endtask

  initial begin
    logic [7:0] sck_v;
    logic [7:0] sck_e;
    Reset_n = 1'b0;
    en      = 1'b0;
    lj_mode = 1'b0;
    ready   = 1'b0;
`ifdef I2S_RX_OVF_EN
    ovf_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      fl[i]   = 24'($urandom);
      fr[i]   = 24'($urandom);
      fdly[i] = 1;
    end
    tick(4);
    chk("rst_sck", 32'(SCK_output), 32'd0);
    chk("rst_ws", 32'(WS_output), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_L", 32'(L_Data), 32'd0);
    chk("rst_R", 32'(R_Data), 32'd0);
`ifdef I2S_RX_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    Reset_n = 1'b1;
    tick(3);

    // Standard I2S capture
    q.delete();
    fl[0] = 24'hA5C3F1;
    fr[0] = 24'h123456;
    start();
    wait_valid("i2s", 227);
    pop_chk("i2s");
    en = 1'b0;
    tick(3);

    // Reset mid-frame while a frame is held, then SCK/WS cadence
    q.delete();
    start();
    tick_to(42);
    Reset_n = 1'b0;
    #1;
    chk("mrst_sck", 32'(SCK_output), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_L", 32'(L_Data), 32'd0);
    chk("mrst_R", 32'(R_Data), 32'd0);
    tick(2);
    Reset_n = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      sck_v[k-1] = SCK_output;
      sck_e[k-1] = ((k % CD) >= CD / 2);
    end
    chk("sck_pattern", 32'(sck_v), 32'(sck_e));
    tick_to(127);
    chk("ws_127", 32'(WS_output), 32'd0);
    tick_to(128);
    chk("ws_128", 32'(WS_output), 32'd1);
    tick_to(256);
    chk("ws_256", 32'(WS_output), 32'd0);
    en = 1'b0;
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    chk("drain_valid", 32'(valid), 32'd0);

    // Left-justified, with a mid-frame mode toggle
    q.delete();
    lj_mode = 1'b1;
    fl[0] = 24'hA5C3F1;
    fr[0] = 24'h123456;
    fdly[0] = 0;
    fdly[1] = 0;
    fdly[2] = 1;
    start();
    wait_valid("lj", 223);
    pop_chk("lj");
    accept("lj");
    tick_to(300);
    lj_mode = 1'b0;
    wait_valid("lj_f1", 479);
    pop_chk("lj_f1");
    accept("lj_f1");
    wait_valid("i2s_f2", 739);
    pop_chk("i2s_f2");
    accept("i2s_f2");
    en = 1'b0;
    for (int i = 0; i < 8; i++) fdly[i] = 1;
    tick(3);

    // Overrun: two frames without ready
    q.delete();
    fl[0] = 24'h111111;
    fr[0] = 24'h222222;
    fl[1] = 24'h000001;
    fr[1] = 24'h000002;
    start();
    wait_valid("ovr0", 227);
    pop_chk("ovr0");
`ifdef I2S_RX_OVF_EN
    chk("ovr0_ovf", 32'(ovf), 32'd0);
`endif
    tick_to(482);
    chk("hold_L", 32'(L_Data), 32'h111111);
    tick_to(483);
    chk("ovr1_valid", 32'(valid), 32'd1);
    pop_chk("ovr1");
`ifdef I2S_RX_OVF_EN
    chk("ovr1_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
`endif
    accept("ovr1");
    en = 1'b0;
    tick(3);

    // ready exactly on the load edge
    q.delete();
    fl[0] = 24'hABCDEF;
    fr[0] = 24'hFEDCBA;
    fl[1] = 24'h13579B;
    fr[1] = 24'h2468AC;
    start();
    wait_valid("le0", 227);
    pop_chk("le0");
    tick_to(482);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("le1_valid", 32'(valid), 32'd1);
    pop_chk("le1");
`ifdef I2S_RX_OVF_EN
    chk("le1_ovf", 32'(ovf), 32'd0);
`endif
    accept("le1");
    en = 1'b0;
    tick(3);

    // Abort at bit 10, re-enable 50 clk later
    q.delete();
    fl[0] = 24'h0C0FFE;
    fr[0] = 24'h00BEEF;
    start();
    tick_to(40);
    en = 1'b0;
    tick(50);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_q", 32'(q.size()), 32'd0);
    start();
    wait_valid("reen", 227);
    pop_chk("reen");
    chk("reen_q", 32'(q.size()), 32'd0);
    accept("reen");
    en = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_rx_core.md
# i2s_rx_core

Parametrised I2S / left-justified receive master for MEMS microphones. Generates SCK and WS from the system clock, deserialises left and right samples from SD, and presents each stereo frame on a valid/ready output port. Successor to the fixed 24-bit stereo capture path; the frame-gating key logic stays outside this block and drives `en`.

## Interface

Parameters:
- `CLK_DIV`, default 28: `clk` cycles per SCK period. Even, ≥ 4.
- `SLOT_BITS`, default 32: SCK periods per channel slot. Frame length is 2·SLOT_BITS bits.
- `DATA_BITS`, default 24: captured sample width. DATA_BITS ≤ SLOT_BITS−1.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `Reset_n` in 1: asynchronous active-low reset.
- `en` in 1: capture enable. Low holds the block idle.
- `lj_mode` in 1: 0 = standard I2S (1-bit delay), 1 = left-justified (no delay). Sampled at the frame start.
- `SD_input` in 1: serial data from the microphone.
- `SCK_output` out 1: bit clock.
- `WS_output` out 1: word select. 0 = left, 1 = right.
- `L_Data` out DATA_BITS: left sample, MSB first as received.
- `R_Data` out DATA_BITS: right sample.
- `valid` out 1: frame available on `L_Data` / `R_Data`.
- `ready` in 1: consumer accepts the frame.
- `ovf` out 1: sticky overrun flag. Present only with `I2S_RX_OVF_EN`.
- `ovf_clr` in 1: clears `ovf`. Present only with `I2S_RX_OVF_EN`.

## Operation

Counters:
- `phase` counts 0..CLK_DIV−1 and wraps.
- `bit_idx` counts 0..2·SLOT_BITS−1 and increments when `phase` wraps.
- Both counters are held at 0 while `en` = 0.

Clock outputs:
- SCK_output = (phase > CLK_DIV/2−1).
- WS_output = (bit_idx ≥ SLOT_BITS).
- Both are registered-equivalent decodes of the counters and are 0 when idle.

Sampling:
- The sample strobe fires when phase == CLK_DIV/2−1, i.e. at the SCK rising edge.
- DLY = 0 if the latched mode is left-justified, else 1.
- The latched mode comes from `lj_mode`, captured when bit_idx = 0 and phase = 0.
- Left shift register (left shift, SD into LSB) updates on strobes where DLY ≤ bit_idx < DLY+DATA_BITS.
- Right shift register updates on strobes where SLOT_BITS+DLY ≤ bit_idx < SLOT_BITS+DLY+DATA_BITS.
- Bits outside these windows are ignored.

Frame completion:
- Frame-done is the strobe at bit_idx = SLOT_BITS+DLY+DATA_BITS−1.
- On the next clk edge, L_Data/R_Data load both shift registers and valid is set to 1.

Output handshake:
- A transfer occurs on any clk edge where valid = 1 and ready = 1.
- After a transfer, valid clears unless a new frame loads on the same edge.
- A frame load while valid = 1 and ready = 0 overwrites the held data. This is an overrun.
- A frame load on the same edge as a transfer: the new data loads, valid stays 1, and it is not an overrun.
- L_Data/R_Data are stable while valid = 1 and ready = 0, except when overwritten by an overrun.

Disable:
- Dropping `en` mid-frame aborts the partial frame. The counters and shift registers go to 0 on the next edge.
- A held valid frame is kept until it is accepted.
- Raising `en` starts a new frame at bit_idx = 0.

Reset: all state clears asynchronously.

## Timing

- Reset values: SCK_output 0, WS_output 0, L_Data 0, R_Data 0, valid 0, ovf 0.
- Frame period: 2·SLOT_BITS·CLK_DIV clk cycles. Default is 1792.
- Latency, from `en` rising (counters start at 0 on the following edge) to valid: (SLOT_BITS+DLY+DATA_BITS−1)·CLK_DIV + CLK_DIV/2 + 1 cycles.
  - Defaults, I2S mode: bit 56, 1583 cycles.
  - Defaults, left-justified: bit 55, 1555 cycles.
- Mode changes take effect at the next frame start only.
- Counter widths are $clog2 of their ranges. There is no arithmetic beyond the counter wraps.

## Configuration

- `I2S_RX_OVF_EN` defined:
  - `ovf` sets on an overrun edge.
  - `ovf` clears on `ovf_clr` = 1.
  - When set and clear occur on the same edge, set wins.
- `I2S_RX_OVF_EN` undefined:
  - The `ovf` and `ovf_clr` ports and their logic are absent.
  - Overwrite behaviour is unchanged.

## Test plan

Bench parameters: CLK_DIV=4, SLOT_BITS=32, DATA_BITS=24. Frame = 256 clk.

- Reset mid-frame, then release with en=1 → all outputs 0 immediately. SCK toggles every 2 clk and WS toggles every 128 clk.
- I2S mode, left = 0xA5C3F1, right = 0x123456 driven MSB at bit 1/33 → valid on cycle 227 after en. L_Data=0xA5C3F1, R_Data=0x123456.
- lj_mode=1, same words at bits 0/32 → valid at cycle 223, same data. Toggling lj_mode mid-frame has no effect until the next frame.
- ready held 0 for 2 frames (second frame 0x000001 / 0x000002) → data overwritten to 0x000001/0x000002 and ovf=1. ovf_clr pulse → ovf=0. Build without the macro: ports absent, data still overwritten.
- ready asserted exactly on the frame-load edge → valid stays 1, new data loads, ovf stays 0.
- en dropped at bit 10 and raised 50 clk later → no valid from the partial frame. The next valid arrives 227 cycles after the re-enable.
